// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter that shares one 4:1 mux among four requesters.
//   The arbiter drives the mux selects (address1/address0) and returns a
//   one-hot grant. An owner keeps the mux until it drops its request. All
//   outputs are registered, so no combinational path runs from req to any
//   output.
//
// Ports
//   clk               rising-edge clock
//   reset_n           asynchronous active-low reset
//   req0..req3        level requests, held high for the whole transfer
//   grant0..grant3    one-hot grant; grantN routes inN to the mux output
//   address1/address0 mux select (MSB/LSB), equal to the granted index
//   busy              high while any grant is asserted
//   timeout           one-cycle pulse when an owner is forcibly revoked
//                     (this port exists only with MUX_ARB_TIMEOUT_EN)
//
// Configuration
//   MUX_ARB_TIMEOUT_EN  When defined, this macro adds the HOLD_MAX parameter
//                       (1..255), an 8-bit hold counter and the timeout port.
//                       An owner that has held the grant for HOLD_MAX cycles
//                       is revoked if another requester is waiting.
module mux_rr_arbiter
`ifdef MUX_ARB_TIMEOUT_EN
#(
    parameter int HOLD_MAX = 8
)
`endif
(
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    output logic grant0,
    output logic grant1,
    output logic grant2,
    output logic grant3,
    output logic address0,
    output logic address1,
    output logic busy
`ifdef MUX_ARB_TIMEOUT_EN
    ,
    output logic timeout
`endif
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] addr;   // doubles as the current owner index
    logic [1:0] last;   // most recently released owner; it has lowest priority
    logic [2:0] pick_idle;
    logic [2:0] pick_next;

    assign req = {req3, req2, req1, req0};

    // Returns {found, index}. Candidates are base+1, base+2, base+3, base
    // (mod 4). The loop runs from the farthest candidate to the nearest, so
    // the nearest requesting candidate is written last and wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] c;
        res = '0;
        for (int i = 4; i >= 1; i--) begin
            c = base + 2'(i);
            if (r[c]) res = {1'b1, c};
        end
        return res;
    endfunction

    assign pick_idle = rr_pick(req, last);
    // The owner is masked out and the search starts after the owner. On a
    // release, req[owner] is already 0, so the same search also serves a
    // forced revocation.
    assign pick_next = rr_pick(req & ~grant, addr);

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] cnt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
            addr  <= '0;
            busy  <= 1'b0;
            last  <= 2'd3;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt     <= '0;
            timeout <= 1'b0;
`endif
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // The address is left alone here, so the mux keeps the
                    // previous owner selected while the arbiter is idle.
                    if (pick_idle[2]) begin
                        grant <= 4'b0001 << pick_idle[1:0];
                        addr  <= pick_idle[1:0];
                        busy  <= 1'b1;
                        state <= GRANT;
`ifdef MUX_ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!req[addr]) begin
                        // On release, hand over on the same edge so the mux
                        // sees no idle bubble.
                        last <= addr;
                        if (pick_next[2]) begin
                            grant <= 4'b0001 << pick_next[1:0];
                            addr  <= pick_next[1:0];
                        end else begin
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
`ifdef MUX_ARB_TIMEOUT_EN
                        cnt <= '0;
`endif
                    end
`ifdef MUX_ARB_TIMEOUT_EN
                    else if (cnt == CNT_LAST) begin
                        // The hold limit is reached. Revoke only if someone
                        // else is waiting; otherwise the counter stays
                        // saturated and the owner keeps the grant.
                        if (pick_next[2]) begin
                            last    <= addr;
                            grant   <= 4'b0001 << pick_next[1:0];
                            addr    <= pick_next[1:0];
                            cnt     <= '0;
                            timeout <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant0   = grant[0];
    assign grant1   = grant[1];
    assign grant2   = grant[2];
    assign grant3   = grant[3];
    assign address0 = addr[0];
    assign address1 = addr[1];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter.
// The stimulus side drives the requests at each falling edge. It advances a
// behavioural reference model by one rising edge and queues the outputs that
// the model expects after that edge. A separate monitor pops one entry after
// each rising edge and compares it with the DUT outputs.
module tb_mux_rr_arbiter;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req     = 4'b0000;
    logic       grant0, grant1, grant2, grant3;
    logic       address0, address1, busy;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HOLD_MAX = 8;
    logic timeout;
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    always #5 clk = ~clk;

`ifdef MUX_ARB_TIMEOUT_EN
    mux_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
`else
    mux_rr_arbiter dut (
`endif
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req[0]),
        .req1     (req[1]),
        .req2     (req[2]),
        .req3     (req[3]),
        .grant0   (grant0),
        .grant1   (grant1),
        .grant2   (grant2),
        .grant3   (grant3),
        .address0 (address0),
        .address1 (address1),
        .busy     (busy)
`ifdef MUX_ARB_TIMEOUT_EN
        ,
        .timeout  (timeout)
`endif
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] addr;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state. An owner of -1 means no requester holds the mux.
    int m_owner, m_last, m_addr, m_cnt;
    bit m_tmo;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns the first of the n candidates from+1, from+2, ... (mod 4) whose
    // request is high, or -1 if none of them is requesting.
    function automatic int search(input logic [3:0] r, input int from, input int n);
        int c;
        for (int k = 1; k <= n; k++) begin
            c = (from + k) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 3; m_addr = 0; m_cnt = 0; m_tmo = 0;
    endtask

    // Advances the model by one rising edge using the request vector r.
    task automatic model_edge(input logic [3:0] r);
        int w;
        m_tmo = 0;
        if (m_owner < 0) begin
            w = search(r, m_last, 4);
            if (w >= 0) begin m_owner = w; m_addr = w; m_cnt = 0; end
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            w       = search(r, m_owner, 4);
            m_owner = w;
            if (w >= 0) m_addr = w;
            m_cnt   = 0;
        end
`ifdef MUX_ARB_TIMEOUT_EN
        else if (m_cnt == HOLD_MAX - 1) begin
            w = search(r, m_owner, 3);
            if (w >= 0) begin
                m_last = m_owner; m_owner = w; m_addr = w; m_cnt = 0; m_tmo = 1;
            end
        end else begin
            m_cnt++;
        end
`endif
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.addr  = 2'(m_addr);
        e.busy  = (m_owner >= 0);
        e.tmo   = m_tmo;
        return e;
    endfunction

    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        model_edge(r);
        q.push_back(cur_exp());
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, {grant3, grant2, grant1, grant0}, 0);
        chk({tag, "_addr"}, {address1, address0}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    // Releases reset at a falling edge and applies r before the next rising edge.
    task automatic release_with(input logic [3:0] r);
        @(negedge clk);
        reset_n = 1'b1;
        req     = r;
        model_reset();
        model_edge(r);
        q.push_back(cur_exp());
    endtask

    // Asserts reset between clock edges and checks that the outputs clear at
    // once, without waiting for an edge.
    task automatic async_reset(input logic [3:0] r);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        q.delete();
        release_with(r);
    endtask

    // Monitor: compares the expected entry for each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant", {grant3, grant2, grant1, grant0}, e.grant);
                chk("addr", {address1, address0}, e.addr);
                chk("busy", busy, e.busy);
                chk("timeout", timeout, e.tmo);
            end
        end
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Everyone requests at once, so requester 0 wins first.
        release_with(4'b1111);
        step(4'b1111);
        step(4'b1111);
        // Each owner drops its request in turn: 0 -> 1 -> 2 -> 3 -> 0.
        step(4'b1110);
        step(4'b1101);
        step(4'b1011);
        step(4'b0111);
        // The grant goes to 2. Requester 2 then releases and re-requests
        // together with 1, and rotation after 2 favours 1.
        step(4'b0100);
        step(4'b0100);
        step(4'b0000);
        step(4'b0110);
        step(4'b0110);
        // Owner 3 drops with no other request: the arbiter goes idle and the
        // address stays at 3.
        step(4'b1000);
        step(4'b1000);
        step(4'b0000);
        step(4'b0000);
        step(4'b0001);
        step(4'b0001);
        // Reset while requester 1 holds the grant.
        step(4'b0010);
        step(4'b0010);
        async_reset(4'b0110);
        step(4'b0110);
        step(4'b0000);

`ifdef MUX_ARB_TIMEOUT_EN
        // The owner is revoked after HOLD_MAX cycles only when another
        // requester is waiting.
        step(4'b0001);
        repeat (2 * HOLD_MAX + 2) step(4'b0011);
        step(4'b0000);
        step(4'b0001);
        repeat (3 * HOLD_MAX) step(4'b0001);
        step(4'b0000);
`endif

        // Random request traffic with sticky levels, plus one mid-run reset.
        r = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            if (i == 400) async_reset(r);
            else step(r);
        end
        step(4'b0000);

        repeat (4) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
